// File: rtl/chan_scan_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// chan_scan_pkg : shared types for the channel scan controller
// Rev 1.0
// ------------------------------------------------------------------
package chan_scan_pkg;

  localparam int c_STATE_W = 2;

  // 2'b11 is unused and steers back to IDLE in the next-state logic
  typedef enum logic [c_STATE_W-1:0] {
    IDLE   = 2'b00,
    SELECT = 2'b01,
    HOLD   = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/chan_scan_ctrl_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick : combinational rotating-priority picker starting at ptr
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any
);

  logic [SEL_W:0] w_idx;

  // Scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    grant = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = {1'b0, ptr} + (SEL_W+1)'(i);
      if (w_idx >= (SEL_W+1)'(N)) begin
        w_idx = w_idx - (SEL_W+1)'(N);
      end
      if (req[w_idx[SEL_W-1:0]]) begin
        grant = w_idx[SEL_W-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/chan_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// chan_scan_ctrl : shares one channel mux among N result channels
// CHAN_SCAN_FIXED_PRIO_EN selects lowest-index-first arbitration.
// Rev 1.0
// ------------------------------------------------------------------
module chan_scan_ctrl
  import chan_scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     ch_valid,
  output logic [N-1:0]     ch_ack,
  output logic [SEL_W-1:0] mux_sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [SEL_W-1:0] c_LAST    = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] c_ONE     = SEL_W'(1);
  localparam logic [N-1:0]     c_ACK_ONE = N'(1);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_mux_sel, w_mux_sel_nxt;
  logic [N-1:0]       r_ack, w_ack_nxt;
  logic [WIDTH-1:0]   r_out_data, w_out_data_nxt;
  logic [SEL_W-1:0]   r_out_chan, w_out_chan_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_busy;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic [SEL_W-1:0]   w_grant;
  logic               w_any;

`ifdef CHAN_SCAN_FIXED_PRIO_EN
  assign w_pick_ptr = '0;
`else
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;

  // Compare-based wrap keeps the pointer inside 0..N-1 for any N
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (r_state == SELECT) begin
      w_ptr_nxt = (r_mux_sel == c_LAST) ? '0 : r_mux_sel + c_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_nxt;
  end

  assign w_pick_ptr = r_ptr;
`endif

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req   (ch_valid),
    .ptr   (w_pick_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_mux_sel_nxt   = r_mux_sel;
    w_ack_nxt       = '0;
    w_out_data_nxt  = r_out_data;
    w_out_chan_nxt  = r_out_chan;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_mux_sel_nxt = w_grant;
          w_state_nxt   = SELECT;
        end
      end
      SELECT: begin
        // mux_data has settled on the granted channel by now
        w_out_data_nxt  = mux_data;
        w_out_chan_nxt  = r_mux_sel;
        w_out_valid_nxt = 1'b1;
        w_ack_nxt       = c_ACK_ONE << r_mux_sel;
        w_state_nxt     = HOLD;
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mux_sel   <= '0;
      r_ack       <= '0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mux_sel   <= w_mux_sel_nxt;
      r_ack       <= w_ack_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_chan  <= w_out_chan_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign ch_ack    = r_ack;
  assign mux_sel   = r_mux_sel;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_chan_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_chan_scan_ctrl : scoreboard bench, N=4 main instance plus N=3 wrap instance
// Rev 1.0
// ------------------------------------------------------------------
module tb_chan_scan_ctrl;

  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ch_valid, ch_ack;
  logic [SW-1:0] mux_sel, out_chan;
  logic [7:0]    mux_data, out_data;
  logic          out_valid, out_ready, busy;

  logic [2:0]    ch_valid3, ch_ack3;
  logic [1:0]    mux_sel3, out_chan3;
  logic [7:0]    mux_data3, out_data3;
  logic          out_valid3, busy3;
  logic          out_ready3 = 1'b1;

  assign mux_data  = 8'h10 + {6'd0, mux_sel};
  assign mux_data3 = 8'h10 + {6'd0, mux_sel3};

  chan_scan_ctrl #(.N(N), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ack(ch_ack),
    .mux_sel(mux_sel), .mux_data(mux_data), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  chan_scan_ctrl #(.N(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .ch_valid(ch_valid3), .ch_ack(ch_ack3),
    .mux_sel(mux_sel3), .mux_data(mux_data3), .out_data(out_data3),
    .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3), .busy(busy3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit n3_done  = 1'b0;

  typedef struct {int chan; int cyc;} exp_t;
  exp_t ack_q[$];
  int   out_q[$];
  int   m_ptr = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbitration: first requester found walking upward from p, wrapping at N
  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      if (req[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock of stimulus; a grant is predicted whenever the block is idle with requests
  task automatic drive_cycle(input logic [N-1:0] add, input logic rdy);
    @(posedge clk);
    #2;
    ch_valid  = (ch_valid & ~ch_ack) | add;
    out_ready = rdy;
    if (!busy && !rst && ch_valid != '0) begin
      int g;
      g = pick(ch_valid, m_ptr);
      ack_q.push_back('{chan: g, cyc: cyc});
`ifndef CHAN_SCAN_FIXED_PRIO_EN
      m_ptr = (g + 1) % N;
`endif
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((ch_valid != '0 || busy || ack_q.size() != 0 || out_q.size() != 0) && k < 200) begin
      drive_cycle('0, 1'b1);
      k++;
    end
    chk("drain_timeout", k < 200, 1);
  endtask

  // Monitor: matches acks against predicted grants, then transfers against captured results
  always @(negedge clk) begin
    if (!rst) begin
      chk("mux_sel_range", mux_sel < N, 1);
      if (ch_ack != '0) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", ch_ack, 0);
        end else begin
          exp_t e;
          e = ack_q.pop_front();
          chk("ack_onehot", ch_ack, 1 << e.chan);
          chk("ack_latency", cyc, e.cyc + 2);
          chk("ack_out_valid", out_valid, 1);
          chk("ack_out_chan", out_chan, e.chan);
          chk("ack_out_data", out_data, 8'h10 + e.chan);
          out_q.push_back(e.chan);
        end
      end else if (ack_q.size() != 0 && cyc >= ack_q[0].cyc + 2) begin
        chk("missing_ack_chan", -1, ack_q[0].chan);
        void'(ack_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          chk("unexpected_transfer", out_valid, 0);
        end else begin
          int c;
          c = out_q.pop_front();
          chk("xfer_chan", out_chan, c);
          chk("xfer_data", out_data, 8'h10 + c);
        end
      end
    end
  end

  task automatic await3(input int exp);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #2;
      chk("n3_mux_sel_range", mux_sel3 < 3, 1);
      if (ch_ack3 != '0) begin
        found = 1'b1;
        chk("n3_ack", ch_ack3, 1 << exp);
        chk("n3_chan", out_chan3, exp);
        chk("n3_data", out_data3, 8'h10 + exp);
      end
    end
    chk("n3_ack_seen", found, 1);
  endtask

  // N=3: grant 2 then wrap back to 0, never index 3
  initial begin
    ch_valid3 = '0;
    @(negedge rst);
    @(posedge clk);
    #2 ch_valid3 = 3'b100;
    await3(2);
    ch_valid3 = 3'b011;
    await3(0);
    ch_valid3 = 3'b010;
    await3(1);
    ch_valid3 = '0;
    n3_done = 1'b1;
  end

  int seq[$];

  initial begin
    rst       = 1'b1;
    ch_valid  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // reset state and quiet idle
    for (int i = 0; i < 10; i++) begin
      drive_cycle('0, 1'b1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ack", ch_ack, 0);
      chk("idle_mux_sel", mux_sel, 0);
    end

    // all channels requesting continuously
    for (int i = 0; i < 20; i++) begin
      drive_cycle(4'b1111, 1'b1);
      if (ch_ack != '0) seq.push_back(int'(out_chan));
    end
    drain();
    chk("rr_grants", seq.size() >= 5, 1);
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
`ifdef CHAN_SCAN_FIXED_PRIO_EN
      chk("fixed_seq", seq[i], 0);
`else
      chk("rr_seq", seq[i], i % N);
`endif
    end

    // backpressure holds the result stable
    drive_cycle(4'b0001, 1'b0);
    drive_cycle('0, 1'b0);
    drive_cycle('0, 1'b0);
    chk("bp_ack", ch_ack, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      drive_cycle('0, 1'b0);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'h10);
      chk("bp_chan", out_chan, 0);
      chk("bp_no_ack", ch_ack, 0);
    end
    drive_cycle('0, 1'b1);
    drive_cycle('0, 1'b1);
    chk("bp_released", out_valid, 0);
    chk("bp_idle", busy, 0);

    // single request latency
    drive_cycle(4'b0100, 1'b1);
    drive_cycle('0, 1'b1);
    chk("single_not_yet", out_valid, 0);
    drive_cycle('0, 1'b1);
    chk("single_ack", ch_ack, 4'b0100);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'h12);
    chk("single_chan", out_chan, 2);
    drive_cycle('0, 1'b1);
    chk("single_idle", busy, 0);

    // randomized traffic and backpressure
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000,
                  $urandom_range(3) != 0);
    end
    drain();

    for (int k = 0; k < 200 && !n3_done; k++) @(posedge clk);
    chk("n3_finished", n3_done, 1);

    // reset while a result is waiting downstream
    drive_cycle(4'b0010, 1'b0);
    drive_cycle('0, 1'b0);
    drive_cycle('0, 1'b0);
    chk("pre_rst_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_ack", ch_ack, 0);
    chk("rst_busy", busy, 0);
    ack_q.delete();
    out_q.delete();
    m_ptr    = 0;
    ch_valid = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle('0, 1'b1);
      chk("post_rst_ack", ch_ack, 0);
      chk("post_rst_valid", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chan_scan_ctrl.md
Name: chan_scan_ctrl

Overview:
Round-robin scheduler that shares the N:1 channel mux between N pulse-width measurement channels.
- Picks a channel whose result is ready and drives the mux select.
- Registers the selected result one cycle later and acknowledges the channel.
- Presents the result downstream (readout/UART path) on a valid/ready handshake, tagged with the channel index.

Parameters:
- N, 4, number of channels; legal range N >= 2, not required to be a power of two.
- WIDTH, 8, width of each channel result.
- SEL_W, $clog2(N), select/index width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- ch_valid  in  N  per-channel result-ready flags; a channel holds its flag until its ack.
- ch_ack  out  N  one-cycle acknowledge, one-hot or zero.
- mux_sel  out  SEL_W  select to the shared channel mux.
- mux_data  in  WIDTH  output of the shared channel mux (combinational from mux_sel).
- out_data  out  WIDTH  captured result.
- out_chan  out  SEL_W  channel index of out_data.
- out_valid  out  1  out_data/out_chan valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous and active-high, forces:
  - mux_sel=0, ch_ack=0, out_data=0, out_chan=0, out_valid=0, busy=0.
  - Round-robin pointer ptr=0, state=IDLE.
  - Reset asserted mid-operation aborts the transaction: no ack is issued and the pending result is lost.
- FSM states: IDLE, SELECT, HOLD. All outputs are registered.
- IDLE:
  - If any ch_valid bit is set, grant = first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - mux_sel <= grant; next state SELECT.
  - Otherwise stay in IDLE with mux_sel unchanged.
- SELECT (exactly 1 cycle, the mux settle cycle):
  - out_data <= mux_data, out_chan <= mux_sel, out_valid <= 1.
  - ch_ack[mux_sel] <= 1 for this one cycle only.
  - ptr <= mux_sel+1, wrapping to 0 when mux_sel == N-1.
  - Next state HOLD.
  - The ack and capture happen even if ch_valid[mux_sel] dropped during SELECT; the upstream protocol violation is not detected.
- HOLD:
  - out_valid, out_data and out_chan are held stable until out_valid && out_ready.
  - On that transfer cycle: out_valid <= 0, next state IDLE.
  - mux_sel is held throughout.
- Latency:
  - ch_valid sampled in IDLE at cycle t: out_valid rises at t+2 and ch_ack is high during t+2.
  - Fastest turnaround is 3 cycles per result (IDLE -> SELECT -> HOLD with out_ready=1).
- out_ready while out_valid=0 is ignored.
- ch_valid changes during SELECT/HOLD affect only the next IDLE arbitration.
- mux_sel never reaches a value >= N. The ptr wrap is compare-based, not modulo 2^SEL_W.
- All index arithmetic is SEL_W bits wide; no truncation warnings are allowed.

Optional Feature:
- CHAN_SCAN_FIXED_PRIO_EN defined:
  - Arbitration is fixed priority: the lowest-index set ch_valid bit wins.
  - ptr is not implemented.
- Not defined: round-robin as above.
- The FSM, latency and handshake are identical in both builds.

Decomposition:
- Package chan_scan_pkg holds:
  - State typedef: IDLE=2'b00, SELECT=2'b01, HOLD=2'b10; the 2'b11 encoding recovers to IDLE.
  - Localparam for the state width.
- Sub-module rr_pick (combinational) takes req[N] and ptr[SEL_W] and returns grant[SEL_W] and any.
  - Under CHAN_SCAN_FIXED_PRIO_EN its ptr input is tied to 0.
- The shared channel mux stays outside this block; the top level wires mux_sel/mux_data.

Test Plan:
All scenarios use N=4, WIDTH=8, with a behavioural mux model where channel i outputs 8'h10+i.
1. Reset then idle: ch_valid=0 for 10 cycles -> out_valid=0, busy=0, ch_ack=0, mux_sel=0 throughout.
2. Single request: ch_valid=4'b0100 at cycle t, out_ready=1 -> ch_ack=4'b0100 and out_valid=1 with out_data=8'h12, out_chan=2 at t+2; IDLE at t+3.
3. Round-robin fairness: ch_valid=4'b1111 held (re-asserted after each ack), out_ready=1 -> out_chan sequence 0,1,2,3,0; one ack per grant.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data=8'h10 and out_chan=0 are stable, with no further acks; out_ready=1 -> single transfer and return to IDLE.
5. Wrap and non-power-of-2: N=3, last grant=2, ch_valid=3'b011 -> next grant 0, never 3.
6. Reset mid-HOLD: assert rst with out_valid=1 -> all outputs 0 asynchronously, with no ack after release. With CHAN_SCAN_FIXED_PRIO_EN and ch_valid=4'b1111 held -> out_chan=0 repeatedly.
